// File: rtl/cpu_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_uart_tx
//  Purpose  : CPU serial console transmitter -- byte FIFO feeding an 8N1 line.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_uart_tx #(
   parameter int WordSize  = 8,
   parameter int ClkDiv    = 16,
   parameter int FifoDepth = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WordSize-1:0] data_in,
   input  logic                wr,
   output logic                full,
   output logic                busy,
   output logic                overrun,
   output logic                txd
);

   localparam int c_AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int c_CW = $clog2(FifoDepth + 1);
   localparam int c_DW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
   localparam int c_BW = (WordSize > 1) ? $clog2(WordSize) : 1;
   localparam logic [c_DW-1:0] c_DIV_LOAD = c_DW'(ClkDiv - 1);
   localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(WordSize - 1);
   localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(FifoDepth);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t              r_state;
   logic [WordSize-1:0] r_mem [FifoDepth];
   logic [c_AW-1:0]     r_wptr;
   logic [c_AW-1:0]     r_rptr;
   logic [c_CW-1:0]     r_count;
   logic [c_DW-1:0]     r_div;
   logic [c_BW-1:0]     r_bit;
   logic [WordSize-1:0] r_shift;
   logic                r_txd;
   logic                r_full;
   logic                r_busy;
   logic                r_overrun;

   logic                w_tick;
   logic                w_push;
   logic                w_pop;
   logic                w_end_idle;
   logic                w_active_next;
   logic [c_CW-1:0]     w_count_next;

   // Pops happen only from IDLE or at the last clock of a stop bit, so a
   // queued byte follows the previous stop bit with no idle gap.
   always_comb begin
      w_tick        = (r_div == '0);
      w_push        = wr && !r_full;
      w_pop         = (r_count != '0) &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));
      w_end_idle    = (r_state == S_STOP) && w_tick && (r_count == '0);
      w_active_next = ((r_state != S_IDLE) && !w_end_idle) || w_pop;
      w_count_next  = r_count;
      if (w_push && !w_pop)
         w_count_next = r_count + c_CW'(1);
      else if (!w_push && w_pop)
         w_count_next = r_count - c_CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_div     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
         r_full    <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_count   <= w_count_next;
         r_full    <= (w_count_next == c_FULL_CNT);
         r_busy    <= w_active_next || (w_count_next != '0);
         r_overrun <= r_overrun | (wr & r_full);
         if (w_push) begin
            r_mem[r_wptr] <= data_in;
            r_wptr        <= r_wptr + c_AW'(1);
         end
         if (w_pop)
            r_rptr <= r_rptr + c_AW'(1);

         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (w_pop) begin
                  r_shift <= r_mem[r_rptr];
                  r_txd   <= 1'b0;
                  r_div   <= c_DIV_LOAD;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_tick) begin
                  r_txd   <= r_shift[0];
                  r_bit   <= '0;
                  r_div   <= c_DIV_LOAD;
                  r_state <= S_DATA;
               end else begin
                  r_div <= r_div - c_DW'(1);
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  r_div <= c_DIV_LOAD;
                  if (r_bit == c_LAST_BIT) begin
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_shift <= r_shift >> 1;
                     r_txd   <= r_shift[1];
                     r_bit   <= r_bit + c_BW'(1);
                  end
               end else begin
                  r_div <= r_div - c_DW'(1);
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  if (w_pop) begin
                     r_shift <= r_mem[r_rptr];
                     r_txd   <= 1'b0;
                     r_div   <= c_DIV_LOAD;
                     r_state <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_div <= r_div - c_DW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign full    = r_full;
   assign busy    = r_busy;
   assign overrun = r_overrun;
   assign txd     = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_cpu_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_uart_tx
//  Purpose  : Directed and random checks of cpu_uart_tx against a frame model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_uart_tx;

   localparam int CLKDIV = 4;
   localparam int DEPTH  = 4;
   localparam int FRAME  = 10 * CLKDIV;

   logic       clk;
   logic       reset;
   logic [7:0] data_in;
   logic       wr;
   logic       full;
   logic       busy;
   logic       overrun;
   logic       txd;

   int n_assert = 0;
   int n_fail   = 0;

   // model: pending bytes, the frame on the line and the byte log
   logic [7:0] m_q[$];
   logic [7:0] m_acc[$];
   logic [7:0] m_byte;
   logic       m_active;
   int         m_k;
   logic       m_ovr;

   // line decoder
   logic [7:0] rx_q[$];
   logic [7:0] rx_byte;
   logic       rx_active;
   int         rx_ph;

   cpu_uart_tx #(.WordSize(8), .ClkDiv(CLKDIV), .FifoDepth(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .data_in (data_in),
      .wr      (wr),
      .full    (full),
      .busy    (busy),
      .overrun (overrun),
      .txd     (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [7:0] d);
      logic pre_full, pre_ne, pop, e_txd;
      int   idx;
      reset = r; wr = w; data_in = d;
      @(posedge clk);
      if (!r) begin
         m_q.delete(); m_acc.delete();
         m_active = 1'b0; m_k = 0; m_ovr = 1'b0;
      end else begin
         pre_full = (m_q.size() == DEPTH);
         pre_ne   = (m_q.size() != 0);
         pop      = 1'b0;
         if (m_active) begin
            m_k++;
            if (m_k == FRAME) begin
               if (pre_ne) pop = 1'b1;
               else m_active = 1'b0;
            end
         end else if (pre_ne) begin
            pop = 1'b1;
         end
         if (pop) begin
            m_byte = m_q.pop_front();
            m_active = 1'b1;
            m_k = 0;
         end
         if (w) begin
            if (pre_full) m_ovr = 1'b1;
            else begin
               m_q.push_back(d);
               m_acc.push_back(d);
            end
         end
      end
      #1;
      if (!m_active) e_txd = 1'b1;
      else begin
         idx = m_k / CLKDIV;
         if (idx == 0)      e_txd = 1'b0;
         else if (idx >= 9) e_txd = 1'b1;
         else               e_txd = m_byte[idx-1];
      end
      chk("txd", txd, e_txd);
      chk("busy", busy, m_active || (m_q.size() != 0));
      chk("full", full, m_q.size() == DEPTH);
      chk("overrun", overrun, m_ovr);
      // mid-bit sampling receiver
      if (!r) rx_active = 1'b0;
      else if (!rx_active) begin
         if (txd == 1'b0) begin rx_active = 1'b1; rx_ph = 0; end
      end else begin
         rx_ph++;
         if ((rx_ph % CLKDIV) == 2 && rx_ph >= 6 && rx_ph <= 34)
            rx_byte[(rx_ph - 6) / CLKDIV] = txd;
         if (rx_ph == 38) begin
            chk("rx_stop", txd, 1);
            rx_q.push_back(rx_byte);
            rx_active = 1'b0;
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && (m_active || m_q.size() != 0); i++)
         step(1'b1, 1'b0, 8'h00);
      chk("drain_busy", busy, 0);
   endtask

   task automatic check_rx();
      chk("rx_count", rx_q.size(), m_acc.size());
      for (int i = 0; i < rx_q.size() && i < m_acc.size(); i++)
         chk($sformatf("rx_byte%0d", i), rx_q[i], m_acc[i]);
      rx_q.delete();
      m_acc.delete();
   endtask

   initial begin
      logic [7:0] e;
      m_active = 1'b0; m_k = 0; m_ovr = 1'b0; m_byte = 8'h00;
      rx_active = 1'b0; rx_ph = 0; rx_byte = 8'h00;

      // 1: reset held ten cycles, with writes attempted during it
      for (int i = 0; i < 10; i++) step(1'b0, i[0], 8'h3C);

      // 2: single byte, busy falls 41 edges after the write
      step(1'b1, 1'b1, 8'hA5);
      for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 8'h00);
      chk("busy_n40", busy, 1);
      step(1'b1, 1'b0, 8'h00);
      chk("busy_n41", busy, 0);
      if (rx_q.size() > 0) chk("rx_a5", rx_q[0], 8'hA5);
      check_rx();

      // 3: three back-to-back frames
      step(1'b1, 1'b1, 8'h41);
      step(1'b1, 1'b1, 8'h42);
      step(1'b1, 1'b1, 8'h43);
      drain();
      chk("abc_count", rx_q.size(), 3);
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         e = 8'h41 + 8'(i);
         chk("abc_byte", rx_q[i], e);
      end
      check_rx();

      // 4: overflow the FIFO
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 8'h10 + 8'(i));
         if (i == 4) chk("full_5th", full, 1);
      end
      chk("ovr_6th", overrun, 1);
      drain();
      chk("ovf_count", rx_q.size(), 5);
      for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
         e = 8'h10 + 8'(i);
         chk("ovf_byte", rx_q[i], e);
      end
      chk("ovr_sticky", overrun, 1);
      check_rx();

      // 5: reset during data bit 3 of 0xFF, then a clean 0x00
      step(1'b1, 1'b1, 8'hFF);
      for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun, 0);
      step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h00);
      drain();
      chk("zero_count", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("zero_byte", rx_q[0], 8'h00);
      check_rx();

      // 6: write lands on the edge the previous stop bit completes
      step(1'b1, 1'b1, 8'h55);
      for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h80);
      chk("gap_txd_idle", txd, 1);
      step(1'b1, 1'b0, 8'h00);
      chk("gap_txd_start", txd, 0);
      drain();
      chk("gap_count", rx_q.size(), 2);
      if (rx_q.size() > 1) chk("gap_byte", rx_q[1], 8'h80);
      check_rx();

      // random traffic, including bursts that overflow
      for (int i = 0; i < 600; i++)
         step(1'b1, ($urandom_range(0, 2) == 0), 8'($urandom));
      drain();
      check_rx();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_uart_tx.md
Name: cpu_uart_tx

Overview:
- Serial output port for the CSCvon8 CPU.
- The CPU issues a one-cycle write strobe with a byte. The block buffers the byte in a small FIFO and serialises it as 8N1 asynchronous serial on txd.
- It is the transmitting end of the serial console. The bench-side receiver decodes txd and checks program output.
- It sits on the CPU data bus beside the PC/halt logic, in the same clock domain.

Parameters:
- WordSize, 8, data bits per frame and width of data_in.
- ClkDiv, 16, clocks per serial bit. Must be ≥2. Sims use 4.
- FifoDepth, 4, bytes of buffering. Must be a power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- data_in  input  WordSize  byte to transmit; sampled on the clock edge where wr=1.
- wr  input  1  write strobe, one byte per cycle high.
- full  output  1  FIFO holds FifoDepth bytes; writes are rejected.
- busy  output  1  frame in progress or FIFO non-empty.
- overrun  output  1  sticky: a write arrived while full.
- txd  output  1  serial line, idle high.

Behaviour:
- Reset (reset=0 at a posedge):
  - Outputs: txd=1, full=0, busy=0, overrun=0.
  - FIFO pointers and count are zeroed. FSM goes to IDLE; bit and divider counters are cleared.
  - Reset mid-frame aborts the frame: txd=1 from that edge on, and buffered bytes are discarded.
- Write acceptance:
  - A byte is accepted at edge N if wr=1 and full=0 as registered before edge N.
  - A write while full is dropped, even if a pop occurs at the same edge, and sets overrun=1 until reset.
  - Simultaneous accepted write and pop leaves count unchanged.
- FIFO:
  - Circular buffer, FifoDepth entries, first in first out; read and write pointers wrap modulo FifoDepth.
  - full = (count == FifoDepth), registered.
- Frame format (LSB first), each bit held exactly ClkDiv clocks:
  - start bit = 0;
  - data bits data[0]..data[WordSize-1];
  - stop bit = 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into the shift register, drive txd=0, go to START and load the divider.
  - START: after ClkDiv clocks, drive txd=shift[0], go to DATA with bit index 0.
  - DATA: every ClkDiv clocks, shift right and increment the bit index. After bit WordSize-1 has been held ClkDiv clocks, drive txd=1 and go to STOP.
  - STOP: after ClkDiv clocks:
    - if the FIFO is non-empty, pop, drive txd=0 and go to START (no idle gap);
    - else go to IDLE.
- Latency: for a byte accepted at edge N with FSM in IDLE, the FIFO is non-empty after N, the pop happens at N+1, and txd=0 from N+1.
- Frame length: (WordSize+2)·ClkDiv clocks. For defaults and ClkDiv=4, that is 40 clocks.
- busy = (state != IDLE) || (count != 0).
  - It deasserts at the edge where the FSM returns to IDLE with the FIFO empty.
- All outputs are registered; txd has no combinational path from any input.

Test Plan:
1. Reset held 10 cycles, ClkDiv=4 -> txd=1, busy=0, full=0, overrun=0 throughout; then release.
2. Single write 0xA5 at edge N -> txd=0 for edges N+1..N+4. Then 1,0,1,0,0,1,0,1 each 4 clocks, then stop bit 1 for 4 clocks. busy falls at edge N+41; a bench UART receiver decodes 0xA5.
3. Write 0x41, 0x42, 0x43 on consecutive cycles -> three back-to-back 40-clock frames with no idle gap between stop and next start; receiver sees "ABC"; full never asserts.
4. Write 6 bytes 0x10..0x15 on consecutive cycles, FifoDepth=4 -> 0x10 popped at edge N+1, so 0x10..0x14 accepted. full=1 after the 5th write; the 6th write is dropped and overrun=1. Output is 0x10..0x14 only; overrun stays 1 until reset.
5. Write 0xFF, assert reset during data bit 3 -> txd=1 from the next edge, busy=0, FIFO empty. After release, write 0x00 -> a clean frame of 0x00 with no residue of 0xFF.
6. Write 0x80 at the edge where STOP of the previous frame completes (FIFO otherwise empty) -> the FSM enters IDLE, then starts the new frame one clock later; receiver decodes 0x80.
